// File: rtl/nonblocking_ring.sv
// Ring of DEPTH words updated simultaneously each edge; word-parallel load,
// then a counted run of HOLD/ROTATE/MIX/COUNT ending in a one-cycle done pulse.
//
// state | meaning
// IDLE  | accepts load or start; load_ready high
// RUN   | applies the latched op every edge until cycles_left reaches 0 or abort
module nonblocking_ring #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int STEP  = 1,
  parameter int CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       run_len,
  input  logic                   abort,
  output logic [WIDTH*DEPTH-1:0] regs,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       cycles_left
);

  localparam logic [1:0] MODE_HOLD   = 2'b00;
  localparam logic [1:0] MODE_ROTATE = 2'b01;
  localparam logic [1:0] MODE_MIX    = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   word_q [DEPTH];
  logic [WIDTH-1:0]   word_d [DEPTH];
  logic [WIDTH-1:0]   load_w [DEPTH];
  logic [WIDTH-1:0]   rot_w  [DEPTH];
  logic [WIDTH-1:0]   mix_w  [DEPTH];
  logic [WIDTH-1:0]   cnt_w  [DEPTH];
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cycles_left_q, cycles_left_d;
  logic               done_q, done_d;

  // Every candidate next word reads only word_q, so no op sees another word's new value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    localparam int PREV  = (i + DEPTH - 1) % DEPTH;
    localparam int NEXT1 = (i + 1) % DEPTH;
    localparam int NEXT2 = (i + 2) % DEPTH;
    assign load_w[i] = load_data[i*WIDTH +: WIDTH];
    assign rot_w[i]  = word_q[PREV];
    assign mix_w[i]  = word_q[NEXT1] + word_q[NEXT2];
    assign cnt_w[i]  = word_q[i] + STEP_W;
    assign regs[i*WIDTH +: WIDTH] = word_q[i];
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    mode_d        = mode_q;
    cycles_left_d = cycles_left_q;
    done_d        = 1'b0;
    if (state_q == IDLE) begin
      if (load_valid) begin
        word_d = load_w;
      end else if (start && (run_len != '0)) begin
        mode_d        = mode;
        cycles_left_d = run_len;
        state_d       = RUN;
      end
    end else begin
      if (abort) begin
        cycles_left_d = '0;
        state_d       = IDLE;
      end else begin
        case (mode_q)
          MODE_ROTATE: word_d = rot_w;
          MODE_MIX:    word_d = mix_w;
          MODE_COUNT:  word_d = cnt_w;
          default:     word_d = word_q;
        endcase
        cycles_left_d = cycles_left_q - CNT_W'(1);
        if (cycles_left_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      mode_q        <= MODE_HOLD;
      cycles_left_q <= '0;
      done_q        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) word_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      cycles_left_q <= cycles_left_d;
      done_q        <= done_d;
      word_q        <= word_d;
    end
  end

  assign load_ready  = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign cycles_left = cycles_left_q;

endmodule

// File: tb/tb_nonblocking_ring.sv
// Directed bench for nonblocking_ring at WIDTH=32, DEPTH=4 with hand-computed ring values.
module tb_nonblocking_ring;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] load_data;
  logic         start;
  logic [1:0]   mode;
  logic [15:0]  run_len;
  logic         abort;
  logic [127:0] regs;
  logic         busy;
  logic         done;
  logic [15:0]  cycles_left;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] HOLD = 2'b00, ROTATE = 2'b01, MIX = 2'b10, COUNT = 2'b11;

  nonblocking_ring dut (
    .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .start(start), .mode(mode), .run_len(run_len), .abort(abort),
    .regs(regs), .busy(busy), .done(done), .cycles_left(cycles_left)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pk(input logic [31:0] r0, r1, r2, r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_load(input logic [127:0] d);
    load_valid = 1'b1;
    load_data  = d;
    tick();
    load_valid = 1'b0;
    chk("load_regs", regs, d);
  endtask

  // Full run: checks busy, countdown, single done pulse and final ring contents.
  task automatic do_run(input string tag, input logic [1:0] m, input int len, input logic [127:0] exp);
    start   = 1'b1;
    mode    = m;
    run_len = 16'(len);
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_cl0"}, cycles_left, 128'(len));
    for (int j = 1; j <= len; j++) begin
      tick();
      chk({tag, "_cl"}, cycles_left, 128'(len - j));
      chk({tag, "_done"}, done, (j == len));
      chk({tag, "_busy_run"}, busy, (j != len));
    end
    chk({tag, "_regs"}, regs, exp);
    chk({tag, "_ready"}, load_ready, 1'b1);
    tick();
    chk({tag, "_done_drop"}, done, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
    mode = HOLD; run_len = '0; abort = 1'b0;
    #12;
    chk("rst_regs", regs, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cl", cycles_left, '0);
    reset_n = 1'b1;
    tick();
    chk("rst_ready", load_ready, 1'b1);

    // reset mid-run
    start = 1'b1; mode = COUNT; run_len = 16'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("mid_regs_pre", regs, pk(3, 3, 3, 3));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_regs", regs, '0);
    chk("mid_busy", busy, 1'b0);
    chk("mid_cl", cycles_left, '0);
    tick();
    reset_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      tick();
      chk("mid_no_done", done, 1'b0);
    end
    chk("mid_ready", load_ready, 1'b1);

    do_load(pk(30, 20, 15, 5));
    do_run("rot1", ROTATE, 1, pk(5, 30, 20, 15));
    do_run("rot3", ROTATE, 3, pk(30, 20, 15, 5));
    do_run("mix1", MIX, 1, pk(35, 20, 35, 50));

    do_load(pk(30, 20, 15, 5));
    do_run("cnt3", COUNT, 3, pk(33, 23, 18, 8));

    do_load(pk(32'hFFFF_FFFF, 0, 0, 0));
    do_run("wrap", COUNT, 1, pk(0, 1, 1, 1));

    do_load(pk(9, 9, 9, 9));
    do_run("hold", HOLD, 2, pk(9, 9, 9, 9));

    // abort on the 4th RUN cycle
    do_load('0);
    start = 1'b1; mode = COUNT; run_len = 16'd10;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_regs", regs, pk(3, 3, 3, 3));
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cl", cycles_left, '0);
    chk("abort_ready", load_ready, 1'b1);
    tick();
    chk("abort_done2", done, 1'b0);

    // start with run_len = 0
    start = 1'b1; mode = COUNT; run_len = 16'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", busy, 1'b0);
    chk("len0_done", done, 1'b0);
    tick();
    chk("len0_done2", done, 1'b0);
    chk("len0_regs", regs, pk(3, 3, 3, 3));

    // load beats start in the same cycle
    load_valid = 1'b1; load_data = pk(1, 2, 3, 4);
    start = 1'b1; mode = COUNT; run_len = 16'd5;
    tick();
    load_valid = 1'b0; start = 1'b0;
    chk("conf_regs", regs, pk(1, 2, 3, 4));
    chk("conf_busy", busy, 1'b0);
    tick();
    chk("conf_busy2", busy, 1'b0);

    // load during RUN is ignored
    start = 1'b1; mode = HOLD; run_len = 16'd3;
    tick();
    start = 1'b0;
    chk("runld_ready", load_ready, 1'b0);
    load_valid = 1'b1; load_data = pk(7, 7, 7, 7);
    tick();
    load_valid = 1'b0;
    chk("runld_regs", regs, pk(1, 2, 3, 4));
    tick(); tick();
    chk("runld_done", done, 1'b1);
    chk("runld_final", regs, pk(1, 2, 3, 4));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
